// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU pipeline stage barriers.
//   XLEN           : native datapath width, default payload width of a barrier
//   barrierState_t : state encoding of pipeline_barrier (EMPTY / FULL / SKID)
//   occupancyOf()  : number of payloads held in a given barrier state
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BARRIER_EMPTY = 2'd0,
        BARRIER_FULL  = 2'd1,
        BARRIER_SKID  = 2'd2
    } barrierState_t;

    function automatic logic [1:0] occupancyOf(input barrierState_t s);
        case (s)
            BARRIER_FULL: return 2'd1;
            BARRIER_SKID: return 2'd2;
            default:      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/barrier_data_reg.sv
// barrier_data_reg -- enabled payload register with asynchronous reset value.
//   clk   : clock, captures d on rising edge when en is high
//   rst_n : asynchronous active-low reset, loads RESET_DATA
//   en    : load enable
//   d     : next payload (WIDTH bits)
//   q     : held payload (WIDTH bits)
module barrier_data_reg #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: payload storage is reset too, so outData shows a defined value
    // (RESET_DATA) while the barrier is empty rather than X after power-up.
    // NOTE: non-blocking assignment keeps every register sampling the
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_DATA;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_barrier.sv
// pipeline_barrier -- valid/ready stage barrier with one-cycle latency.
//   clk, rst_n         : clock, asynchronous active-low reset
//   inValid/inReady    : upstream handshake, inData is the payload
//   outValid/outReady  : downstream handshake, outData is the payload
//   flush              : synchronous squash of every held entry
//   occupancy          : held entries (0..1, or 0..2 with the skid entry)
// Build option: define PIPELINE_BARRIER_SKID_EN to add a second (skid) entry,
// which makes inReady a registered signal with no path from outReady.
module pipeline_barrier
    import cpu_pkg::*;
#(
    parameter int               WIDTH             = XLEN,
    parameter logic [WIDTH-1:0] RESET_DATA        = '0,
    parameter bit               FLUSH_CLEARS_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    barrierState_t    state, stateNext;
    logic             inXfer, outXfer;
    logic             mainEn;
    logic [WIDTH-1:0] mainD;
`ifdef PIPELINE_BARRIER_SKID_EN
    logic             skidEn;
    logic [WIDTH-1:0] skidD, skidQ;
    logic             inReadyReg;
`endif

    assign outValid  = (state != BARRIER_EMPTY);
    assign inXfer    = inValid & inReady;
    assign outXfer   = outValid & outReady;
    assign occupancy = occupancyOf(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BARRIER_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves it unassigned (which would infer a latch).
        stateNext = state;
        mainEn    = 1'b0;
        mainD     = inData;
`ifdef PIPELINE_BARRIER_SKID_EN
        skidEn    = 1'b0;
        skidD     = inData;
`endif
        if (flush) begin
            // Squash wins over any handshake in the same cycle; an accepted
            // input is dropped on the floor.
            stateNext = BARRIER_EMPTY;
            mainEn    = FLUSH_CLEARS_DATA;
            mainD     = RESET_DATA;
`ifdef PIPELINE_BARRIER_SKID_EN
            skidEn    = FLUSH_CLEARS_DATA;
            skidD     = RESET_DATA;
`endif
        end else begin
            case (state)
                BARRIER_EMPTY: begin
                    if (inXfer) begin
                        stateNext = BARRIER_FULL;
                        mainEn    = 1'b1;
                    end
                end
                BARRIER_FULL: begin
                    if (inXfer && outXfer) begin
                        mainEn = 1'b1;
                    end else if (outXfer) begin
                        stateNext = BARRIER_EMPTY;
`ifdef PIPELINE_BARRIER_SKID_EN
                    end else if (inXfer) begin
                        // Downstream stalled this cycle: park the new payload
                        // behind the one being presented.
                        stateNext = BARRIER_SKID;
                        skidEn    = 1'b1;
`endif
                    end
                end
`ifdef PIPELINE_BARRIER_SKID_EN
                BARRIER_SKID: begin
                    // inReady is low here, so only the drain case exists.
                    if (outXfer) begin
                        stateNext = BARRIER_FULL;
                        mainEn    = 1'b1;
                        mainD     = skidQ;
                    end
                end
`endif
                default: stateNext = BARRIER_EMPTY;
            endcase
        end
    end

    barrier_data_reg #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_mainReg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mainEn),
        .d     (mainD),
        .q     (outData)
    );

`ifdef PIPELINE_BARRIER_SKID_EN
    barrier_data_reg #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
    ) u_skidReg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skidEn),
        .d     (skidD),
        .q     (skidQ)
    );

    // Registered ready: high unless the next state has both entries used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inReadyReg <= 1'b1;
        end else begin
            inReadyReg <= (stateNext != BARRIER_SKID);
        end
    end

    // flush keeps upstream moving; there is no outReady term.
    assign inReady = inReadyReg | flush;
`else
    assign inReady = !outValid | outReady | flush;
`endif

endmodule
